// File: rtl/axc_add_err_meter_if.sv
// Operand/result bus between the error meter (master) and the approximate adder under test (slave).
interface axc_add_err_meter_if #(
    parameter int W = 8
);
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_valid;
    logic [W:0]   res;

    modport master (output op_a, output op_b, output op_valid, input res);
    modport slave  (input op_a, input op_b, input op_valid, output res);
endinterface

// File: rtl/axc_add_err_meter.sv
// Exhaustive error characterisation of an unsigned approximate adder: sweeps every operand pair and
// accumulates MAE/MSE numerators, WCE (with its first pair) and error count. `AXC_ERR_BIAS_EN adds err_bias.
module axc_add_err_meter #(
    parameter int W       = 8,
    parameter int DUT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    axc_add_err_meter_if.master   bus,
    output logic [3*W:0]          err_sum,
    output logic [4*W+1:0]        sq_sum,
    output logic [W:0]            wce,
    output logic [W-1:0]          wce_a,
    output logic [W-1:0]          wce_b,
    output logic [2*W:0]          err_cnt
`ifdef AXC_ERR_BIAS_EN
    ,
    output logic signed [3*W+1:0] err_bias
`endif
);

    localparam int            DW         = $clog2(DUT_LAT + 2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DUT_LAT);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2*W-1:0]  r_cnt;
    logic [DW-1:0]   r_drain;
    logic            r_done;
    logic            w_clear;
    logic            w_finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_SWEEP;
                    w_clear = 1'b1;
                end
            end
            S_SWEEP: begin
                if (r_cnt == '1) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_next   = S_IDLE;
                    w_finish = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The pair counter wraps to zero on its own after the last pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= w_finish;
            r_drain <= (r_state == S_DRAIN) ? r_drain + DW'(1) : '0;
            if (w_clear) begin
                r_cnt <= '0;
            end else if (r_state == S_SWEEP) begin
                r_cnt <= r_cnt + (2*W)'(1);
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign bus.op_valid = (r_state == S_SWEEP);
    assign bus.op_a     = r_cnt[W-1:0];
    assign bus.op_b     = r_cnt[2*W-1:W];

    logic [W:0]   w_exact;
    logic         w_dv;
    logic [W:0]   w_dexact;
    logic [W-1:0] w_da;
    logic [W-1:0] w_db;

    assign w_exact = {1'b0, bus.op_a} + {1'b0, bus.op_b};

    generate
        if (DUT_LAT == 0) begin : g_nodly
            assign w_dv     = bus.op_valid;
            assign w_dexact = w_exact;
            assign w_da     = bus.op_a;
            assign w_db     = bus.op_b;
        end else begin : g_dly
            logic         r_v  [DUT_LAT];
            logic [W:0]   r_ex [DUT_LAT];
            logic [W-1:0] r_a  [DUT_LAT];
            logic [W-1:0] r_b  [DUT_LAT];

            // Shift register keeps the reference data aligned with the DUT pipeline.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        r_v[i]  <= 1'b0;
                        r_ex[i] <= '0;
                        r_a[i]  <= '0;
                        r_b[i]  <= '0;
                    end
                end else begin
                    r_v[0]  <= bus.op_valid;
                    r_ex[0] <= w_exact;
                    r_a[0]  <= bus.op_a;
                    r_b[0]  <= bus.op_b;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        r_v[i]  <= r_v[i-1];
                        r_ex[i] <= r_ex[i-1];
                        r_a[i]  <= r_a[i-1];
                        r_b[i]  <= r_b[i-1];
                    end
                end
            end

            assign w_dv     = r_v[DUT_LAT-1];
            assign w_dexact = r_ex[DUT_LAT-1];
            assign w_da     = r_a[DUT_LAT-1];
            assign w_db     = r_b[DUT_LAT-1];
        end
    endgenerate

    logic signed [W+1:0] w_e;
    logic [W+1:0]        w_neg;
    logic [W:0]          w_abs;
    logic [2*W+1:0]      w_sq;

    assign w_e   = $signed({1'b0, bus.res}) - $signed({1'b0, w_dexact});
    assign w_neg = -w_e;
    assign w_abs = w_e[W+1] ? w_neg[W:0] : w_e[W:0];
    assign w_sq  = {{(W+1){1'b0}}, w_abs} * {{(W+1){1'b0}}, w_abs};

    logic [3*W:0]   r_err_sum;
    logic [4*W+1:0] r_sq_sum;
    logic [W:0]     r_wce;
    logic [W-1:0]   r_wce_a;
    logic [W-1:0]   r_wce_b;
    logic [2*W:0]   r_err_cnt;

    // Strict compare on WCE so ties keep the earliest pair in sweep order.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_err_sum <= '0;
            r_sq_sum  <= '0;
            r_wce     <= '0;
            r_wce_a   <= '0;
            r_wce_b   <= '0;
            r_err_cnt <= '0;
        end else if (w_dv) begin
            r_err_sum <= r_err_sum + {{(2*W){1'b0}}, w_abs};
            r_sq_sum  <= r_sq_sum + {{(2*W){1'b0}}, w_sq};
            r_err_cnt <= r_err_cnt + {{(2*W){1'b0}}, (w_e != '0)};
            if (w_abs > r_wce) begin
                r_wce   <= w_abs;
                r_wce_a <= w_da;
                r_wce_b <= w_db;
            end
        end
    end

    assign err_sum = r_err_sum;
    assign sq_sum  = r_sq_sum;
    assign wce     = r_wce;
    assign wce_a   = r_wce_a;
    assign wce_b   = r_wce_b;
    assign err_cnt = r_err_cnt;

`ifdef AXC_ERR_BIAS_EN
    logic signed [3*W+1:0] r_err_bias;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_err_bias <= '0;
        end else if (w_dv) begin
            r_err_bias <= r_err_bias + {{(2*W){w_e[W+1]}}, w_e};
        end
    end

    assign err_bias = r_err_bias;
`endif

endmodule

// File: tb/tb_axc_add_err_meter.sv
// Bench for axc_add_err_meter: one combinational DUT with selectable error models and one 2-stage
// registered exact DUT; expected metrics come from a software sweep pushed to a scoreboard queue.
module tb_axc_add_err_meter;
    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0;
    logic start2;
    logic busy0, done0, busy2, done2;
    logic [3*W:0]   errSum0, errSum2;
    logic [4*W+1:0] sqSum0, sqSum2;
    logic [W:0]     wce0, wce2;
    logic [W-1:0]   wceA0, wceB0, wceA2, wceB2;
    logic [2*W:0]   errCnt0, errCnt2;
`ifdef AXC_ERR_BIAS_EN
    logic signed [3*W+1:0] bias0, bias2;
`endif

    int mode;
    int cyc   = 0;
    int vcnt0 = 0;
    int vcnt2 = 0;
    int runK;
    int runV;
    int nChecks   = 0;
    int passCount = 0;
    int failCount = 0;

    typedef struct {
        longint errSum;
        longint sqSum;
        longint wce;
        longint wceA;
        longint wceB;
        longint errCnt;
        longint bias;
    } expect_t;

    expect_t sb[$];

    axc_add_err_meter_if #(.W(W)) bus0 ();
    axc_add_err_meter_if #(.W(W)) bus2 ();

    axc_add_err_meter #(.W(W), .DUT_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .bus(bus0),
        .err_sum(errSum0), .sq_sum(sqSum0), .wce(wce0), .wce_a(wceA0), .wce_b(wceB0),
        .err_cnt(errCnt0)
`ifdef AXC_ERR_BIAS_EN
        , .err_bias(bias0)
`endif
    );

    axc_add_err_meter #(.W(W), .DUT_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(bus2),
        .err_sum(errSum2), .sq_sum(sqSum2), .wce(wce2), .wce_a(wceA2), .wce_b(wceB2),
        .err_cnt(errCnt2)
`ifdef AXC_ERR_BIAS_EN
        , .err_bias(bias2)
`endif
    );

    // Approximate adder models: 0 exact, 1 LSB forced low, 2 off by +1, 3 constant zero.
    logic [W:0] sum0;
    always_comb begin
        sum0     = {1'b0, bus0.op_a} + {1'b0, bus0.op_b};
        bus0.res = sum0;
        case (mode)
            1: bus0.res = sum0 & ~((W+1)'(1));
            2: bus0.res = sum0 + (W+1)'(1);
            3: bus0.res = '0;
            default: ;
        endcase
    end

    logic [W:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= {1'b0, bus2.op_a} + {1'b0, bus2.op_b};
        pipe2 <= pipe1;
    end
    assign bus2.res = pipe2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.op_valid) vcnt0 <= vcnt0 + 1;
        if (bus2.op_valid) vcnt2 <= vcnt2 + 1;
    end

    function automatic expect_t modelRun(int m);
        expect_t r = '{default: 0};
        for (int b = 0; b < (1 << W); b++) begin
            for (int a = 0; a < (1 << W); a++) begin
                int exact = a + b;
                int res;
                int e;
                int ae;
                case (m)
                    1: res = exact & ~1;
                    2: res = exact + 1;
                    3: res = 0;
                    default: res = exact;
                endcase
                e  = res - exact;
                ae = (e < 0) ? -e : e;
                r.errSum += ae;
                r.sqSum  += ae * ae;
                r.bias   += e;
                if (e != 0) r.errCnt++;
                if (ae > r.wce) begin
                    r.wce  = ae;
                    r.wceA = a;
                    r.wceB = b;
                end
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        nChecks++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input int m, input bit push);
        if (inst == 0) mode = m;
        if (push) sb.push_back(modelRun((inst == 0) ? m : 0));
        if (inst == 0) start0 = 1'b1;
        else start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        runK = cyc;
        runV = (inst == 0) ? vcnt0 : vcnt2;
        checkOutput("busy_after_start", longint'((inst == 0) ? busy0 : busy2), 1);
        checkOutput("op_valid_first", longint'((inst == 0) ? bus0.op_valid : bus2.op_valid), 1);
        checkOutput("op_a_first", longint'((inst == 0) ? bus0.op_a : bus2.op_a), 0);
        checkOutput("op_b_first", longint'((inst == 0) ? bus0.op_b : bus2.op_b), 0);
    endtask

    task automatic waitResult(input int inst, input int lat);
        bit      seen;
        int      doneEdge;
        int      vc;
        expect_t e;
        longint  oSum, oSq, oWce, oA, oB, oCnt;
        logic    oBusy;
`ifdef AXC_ERR_BIAS_EN
        longint  oBias;
`endif
        seen     = 1'b0;
        doneEdge = 0;
        for (int i = 0; i < N + 64 && !seen; i++) begin
            @(posedge clk);
            #1;
            if ((inst == 0) ? done0 : done2) begin
                seen     = 1'b1;
                doneEdge = cyc;
            end
        end
        if (inst == 0) begin
            oSum = longint'(errSum0); oSq = longint'(sqSum0); oWce = longint'(wce0);
            oA = longint'(wceA0); oB = longint'(wceB0); oCnt = longint'(errCnt0);
            oBusy = busy0; vc = vcnt0;
`ifdef AXC_ERR_BIAS_EN
            oBias = longint'(bias0);
`endif
        end else begin
            oSum = longint'(errSum2); oSq = longint'(sqSum2); oWce = longint'(wce2);
            oA = longint'(wceA2); oB = longint'(wceB2); oCnt = longint'(errCnt2);
            oBusy = busy2; vc = vcnt2;
`ifdef AXC_ERR_BIAS_EN
            oBias = longint'(bias2);
`endif
        end
        checkOutput("done_seen", longint'(seen), 1);
        // Observed after edge doneEdge means cycle doneEdge+1 when start was accepted at edge runK.
        checkOutput("done_cycle", longint'(doneEdge + 1), longint'(runK + N + lat + 2));
        checkOutput("busy_at_done", longint'(oBusy), 0);
        checkOutput("valid_cycles", longint'(vc - runV), longint'(N));
        checkOutput("sb_depth", longint'(sb.size()), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("err_sum", oSum, e.errSum);
            checkOutput("sq_sum", oSq, e.sqSum);
            checkOutput("wce", oWce, e.wce);
            checkOutput("wce_a", oA, e.wceA);
            checkOutput("wce_b", oB, e.wceB);
            checkOutput("err_cnt", oCnt, e.errCnt);
`ifdef AXC_ERR_BIAS_EN
            checkOutput("err_bias", oBias, e.bias);
`endif
        end
        @(posedge clk);
        #1;
        checkOutput("done_width", longint'((inst == 0) ? done0 : done2), 0);
    endtask

    initial begin
        int doneCnt;
        rst    = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", longint'(busy0), 0);
        checkOutput("rst_done", longint'(done0), 0);
        checkOutput("rst_op_valid", longint'(bus0.op_valid), 0);
        checkOutput("rst_op_a", longint'(bus0.op_a), 0);
        checkOutput("rst_op_b", longint'(bus0.op_b), 0);
        checkOutput("rst_err_sum", longint'(errSum0), 0);
        checkOutput("rst_wce", longint'(wce0), 0);
        checkOutput("rst_err_cnt", longint'(errCnt0), 0);

        // A start coinciding with reset must be dropped.
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("start_during_rst", longint'(busy0), 0);

        for (int m = 0; m < 4; m++) begin
            applyStimulus(0, m, 1'b1);
            waitResult(0, 0);
        end

        applyStimulus(0, 3, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", longint'(busy0), 0);
        checkOutput("abort_op_valid", longint'(bus0.op_valid), 0);
        checkOutput("abort_op_a", longint'(bus0.op_a), 0);
        checkOutput("abort_err_sum", longint'(errSum0), 0);
        checkOutput("abort_sq_sum", longint'(sqSum0), 0);
        checkOutput("abort_wce", longint'(wce0), 0);
        checkOutput("abort_wce_a", longint'(wceA0), 0);
        checkOutput("abort_err_cnt", longint'(errCnt0), 0);
        rst     = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < N + 20; i++) begin
            @(posedge clk);
            #1;
            if (done0) doneCnt++;
        end
        checkOutput("abort_no_done", longint'(doneCnt), 0);

        applyStimulus(0, 3, 1'b1);
        waitResult(0, 0);

        applyStimulus(2, 0, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        waitResult(2, 2);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_restart_busy", longint'(busy2), 0);

        $display("%0d/%0d checks passed", passCount, nChecks);
        $finish;
    end
endmodule
